// File: rtl/dilithium_pkg.sv
// Shared w1 packing constants and FSM encoding for the streaming polyvec w1 packer.
package dilithium_pkg;
  localparam int W1_N    = 256;
  localparam int W1_B4   = 4;
  localparam int W1_B6   = 6;
  localparam int W1_LIM4 = 16;
  localparam int W1_LIM6 = 44;
  localparam int WPP4    = W1_N * W1_B4 / 32;
  localparam int WPP6    = W1_N * W1_B6 / 32;
  localparam int ACC_W   = 38;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} st_e;
endpackage

// File: rtl/polyveck_pack_w1_stream_if.sv
// Coefficient-in / packed-word-out stream bundle for polyveck_pack_w1_stream.
interface polyveck_pack_w1_stream_if #(
  parameter int COEFF_W = 32,
  parameter int OUT_W   = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [COEFF_W-1:0] in_coeff;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_poly_last;
  logic               out_last;

  modport slave  (input  in_valid, in_coeff, out_ready,
                  output in_ready, out_valid, out_data, out_poly_last, out_last);
  modport master (output in_valid, in_coeff, out_ready,
                  input  in_ready, out_valid, out_data, out_poly_last, out_last);
endinterface

// File: rtl/polyveck_pack_w1_stream_accum.sv
// w1_bit_accum: 38-bit little-endian shift accumulator; push ORs b bits at fill, pop drops 32.
module w1_bit_accum
  import dilithium_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        b6,
  input  logic        push,
  input  logic [5:0]  push_bits,
  input  logic        pop,
  output logic [5:0]  fill,
  output logic [31:0] word
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [5:0]       fill_q, fill_d;
  logic [5:0]       bits_m;

  always_comb begin
    bits_m = b6 ? push_bits : {2'b00, push_bits[3:0]};
    acc_d  = acc_q;
    fill_d = fill_q;
    // Pop first so a same-cycle push lands at the post-shift position.
    if (pop) begin
      acc_d  = acc_q >> 32;
      fill_d = fill_q - 6'd32;
    end
    if (push) begin
      acc_d  = acc_d | (ACC_W'(bits_m) << fill_d);
      fill_d = fill_d + (b6 ? 6'd6 : 6'd4);
    end
    if (clr) begin
      acc_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
  assign word = acc_q[31:0];
endmodule

// File: rtl/polyveck_pack_w1_stream.sv
// Streaming K-polynomial w1 packer (4 or 6 bits/coeff). Define W1_RANGE_CHECK_EN for the sticky err output.
module polyveck_pack_w1_stream
  import dilithium_pkg::*;
#(
  parameter int K       = 6,
  parameter int N       = W1_N,
  parameter int COEFF_W = 32,
  parameter int OUT_W   = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mode6,
  polyveck_pack_w1_stream_if.slave ifc,
  output logic busy,
`ifdef W1_RANGE_CHECK_EN
  output logic err,
`endif
  output logic done
);
  localparam int CIW = $clog2(N);
  localparam int PIW = $clog2(K + 1);
  localparam int WIW = $clog2(N * W1_B6 / 32 + 1);

  st_e              state_q, state_d;
  logic             mode6_q, mode6_d;
  logic [CIW-1:0]   cidx_q, cidx_d;
  logic [PIW-1:0]   ipoly_q, ipoly_d, opoly_q, opoly_d;
  logic             in_all_q, in_all_d;
  logic [WIW-1:0]   widx_q, widx_d;
  logic [WIW-1:0]   wpp_m1;
  logic [5:0]       fill;
  logic [31:0]      acc_word;
  logic             run, start_ok, accept, pop;
  logic             in_ready, out_valid, poly_last, vec_last;

  assign run       = (state_q == ST_RUN);
  assign start_ok  = start && (state_q == ST_IDLE);
  assign wpp_m1    = mode6_q ? WIW'(N * W1_B6 / 32 - 1) : WIW'(N * W1_B4 / 32 - 1);
  assign in_ready  = run && (fill < 6'd32) && !in_all_q;
  assign out_valid = run && (fill >= 6'd32);
  assign poly_last = out_valid && (widx_q == wpp_m1);
  assign vec_last  = poly_last && (opoly_q == PIW'(K - 1));
  assign accept    = ifc.in_valid && in_ready;
  assign pop       = out_valid && ifc.out_ready;

  assign ifc.in_ready      = in_ready;
  assign ifc.out_valid     = out_valid;
  assign ifc.out_data      = OUT_W'(acc_word);
  assign ifc.out_poly_last = poly_last;
  assign ifc.out_last      = vec_last;

  w1_bit_accum u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .b6        (mode6_q),
    .push      (accept),
    .push_bits (ifc.in_coeff[5:0]),
    .pop       (pop),
    .fill      (fill),
    .word      (acc_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)            state_d = ST_RUN;
      ST_RUN:  if (pop && vec_last)  state_d = ST_DONE;
      ST_DONE:                       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Input side counts coefficients/polys; output side counts words/polys independently.
  always_comb begin
    mode6_d  = mode6_q;
    cidx_d   = cidx_q;
    ipoly_d  = ipoly_q;
    in_all_d = in_all_q;
    widx_d   = widx_q;
    opoly_d  = opoly_q;
    if (start_ok || state_q == ST_DONE) begin
      mode6_d  = start_ok ? mode6 : mode6_q;
      cidx_d   = '0;
      ipoly_d  = '0;
      in_all_d = 1'b0;
      widx_d   = '0;
      opoly_d  = '0;
    end else begin
      if (accept) begin
        if (cidx_q == CIW'(N - 1)) begin
          cidx_d = '0;
          if (ipoly_q == PIW'(K - 1)) in_all_d = 1'b1;
          else                        ipoly_d  = ipoly_q + 1'b1;
        end else begin
          cidx_d = cidx_q + 1'b1;
        end
      end
      if (pop) begin
        if (widx_q == wpp_m1) begin
          widx_d  = '0;
          opoly_d = opoly_q + 1'b1;
        end else begin
          widx_d = widx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode6_q  <= 1'b0;
      cidx_q   <= '0;
      ipoly_q  <= '0;
      in_all_q <= 1'b0;
      widx_q   <= '0;
      opoly_q  <= '0;
    end else begin
      mode6_q  <= mode6_d;
      cidx_q   <= cidx_d;
      ipoly_q  <= ipoly_d;
      in_all_q <= in_all_d;
      widx_q   <= widx_d;
      opoly_q  <= opoly_d;
    end
  end

`ifdef W1_RANGE_CHECK_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (start_ok)
      err_d = 1'b0;
    else if (accept && ifc.in_coeff >= (mode6_q ? COEFF_W'(W1_LIM6) : COEFF_W'(W1_LIM4)))
      err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_coeff_hi;
  assign unused_coeff_hi = |ifc.in_coeff[COEFF_W-1:6];
`endif
endmodule

// File: tb/tb_polyveck_pack_w1_stream.sv
// Self-checking bench for polyveck_pack_w1_stream: table of vector runs against a bit-list packing model.
module tb_polyveck_pack_w1_stream;
  localparam int K = 6;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode6 = 1'b0;
  logic busy, done;
`ifdef W1_RANGE_CHECK_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  polyveck_pack_w1_stream_if #(.COEFF_W(32), .OUT_W(32)) ifc ();

  polyveck_pack_w1_stream #(.K(K), .N(N), .COEFF_W(32), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode6 (mode6),
    .ifc   (ifc),
    .busy  (busy),
`ifdef W1_RANGE_CHECK_EN
    .err   (err),
`endif
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode6;
    int          pat;        // 0: i%16, 1: (i+1)%44, 2: random 32-bit, 3: pat1 with a 44 at index 10
    int          bp_pct;     // percent of cycles with out_ready low
    bit          start_mid;  // pulse start (with flipped mode) during RUN
    int          abort_word; // assert reset when this many words have gone out (-1: never)
    bit          chk_first;
    logic [31:0] exp_first;
    int          exp_words;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},  32'(busy), 0);
    chk({nm, "_done"},  32'(done), 0);
    chk({nm, "_ovld"},  32'(ifc.out_valid), 0);
    chk({nm, "_irdy"},  32'(ifc.in_ready), 0);
    chk({nm, "_odata"}, ifc.out_data, 0);
    chk({nm, "_plast"}, 32'(ifc.out_poly_last), 0);
    chk({nm, "_last"},  32'(ifc.out_last), 0);
`ifdef W1_RANGE_CHECK_EN
    chk({nm, "_err"},   32'(err), 0);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned coefs[K*N];
    bit          bitv[];
    logic [31:0] expw[$];
    int b       = v.mode6 ? 6 : 4;
    int lim     = v.mode6 ? 44 : 16;
    int total_c = K * N;
    int total_w = K * N * b / 32;
    int wpp     = N * b / 32;
    int ic = 0, wc = 0, cyc = 0, fin = -1;
    bit prev_hold = 0, first_seen = 0, extra_chk = 0, exp_err = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] w;

    for (int i = 0; i < total_c; i++) begin
      case (v.pat)
        0:       coefs[i] = i % 16;
        1, 3:    coefs[i] = (i + 1) % 44;
        default: coefs[i] = $urandom;
      endcase
    end
    if (v.pat == 3) coefs[10] = 44;
    foreach (coefs[i]) if (coefs[i] >= lim) exp_err = 1;

    // Reference: flat little-endian bit list, sliced into 32-bit words.
    bitv = new[total_c * b];
    for (int i = 0; i < total_c; i++)
      for (int j = 0; j < b; j++) bitv[i*b + j] = (coefs[i] >> j) & 1;
    for (int k = 0; k < total_w; k++) begin
      w = '0;
      for (int j = 0; j < 32; j++) w[j] = bitv[k*32 + j];
      expw.push_back(w);
    end

    @(negedge clk);
    ifc.in_valid = 0; ifc.out_ready = 0;
    start = 1; mode6 = v.mode6;
    @(negedge clk);
    start = 0;
    #1;
    chk("busy_after_start", 32'(busy), 1);
`ifdef W1_RANGE_CHECK_EN
    chk("err_clr_on_start", 32'(err), 0);
`endif
    #1;
    forever begin
      ifc.in_valid  = 1;
      ifc.in_coeff  = (ic < total_c) ? coefs[ic] : $urandom;
      start         = (v.start_mid && cyc == 40);
      mode6         = (v.start_mid && cyc == 40) ? ~v.mode6 : v.mode6;
      ifc.out_ready = ($urandom_range(0, 99) >= v.bp_pct);
      #1;
      if (prev_hold) begin
        chk("hold_valid", 32'(ifc.out_valid), 1);
        chk("hold_data", ifc.out_data, prev_data);
      end
      if (ic == total_c && !extra_chk) begin
        extra_chk = 1;
        chk("extra_in_ready", 32'(ifc.in_ready), 0);
      end
      if (ifc.out_valid && !first_seen) begin
        first_seen = 1;
        chk("first_latency", ic, b == 4 ? 8 : 6);
      end
      if (ifc.in_valid && ifc.in_ready) ic++;
      if (ifc.out_valid && ifc.out_ready) begin
        if (wc < total_w) begin
          chk("word_data", ifc.out_data, expw[wc]);
          chk("poly_last", 32'(ifc.out_poly_last), 32'((wc % wpp) == wpp - 1));
          chk("vec_last", 32'(ifc.out_last), 32'(wc == total_w - 1));
          if (wc == 0 && v.chk_first) chk("first_word", ifc.out_data, v.exp_first);
        end
        wc++;
        if (wc == total_w) fin = cyc;
      end
      if (v.abort_word >= 0 && wc == v.abort_word) begin
        rst_n = 0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1;
        ifc.in_valid = 0; ifc.out_ready = 0; start = 0;
        return;
      end
      prev_hold = ifc.out_valid && !ifc.out_ready;
      prev_data = ifc.out_data;
      if (fin >= 0 && cyc == fin + 1) chk("done_pulse", 32'(done), 1);
      if (fin >= 0 && cyc == fin + 2) begin
        chk("done_clear", 32'(done), 0);
        chk("busy_clear", 32'(busy), 0);
        break;
      end
      cyc++;
      if (cyc > 6000) begin
        chk("timeout", 32'(wc), 32'(total_w));
        break;
      end
      @(negedge clk);
    end
    chk("word_count", wc, v.exp_words);
`ifdef W1_RANGE_CHECK_EN
    chk("err_sticky", 32'(err), 32'(exp_err));
`endif
    ifc.in_valid = 0; ifc.out_ready = 0; start = 0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{mode6:0, pat:0, bp_pct:0,  start_mid:0, abort_word:-1,  chk_first:1, exp_first:32'h76543210, exp_words:192};
    vecs[1] = '{mode6:1, pat:1, bp_pct:0,  start_mid:0, abort_word:-1,  chk_first:1, exp_first:32'h85103081, exp_words:288};
    vecs[2] = '{mode6:0, pat:2, bp_pct:50, start_mid:0, abort_word:-1,  chk_first:0, exp_first:32'h0,        exp_words:192};
    vecs[3] = '{mode6:1, pat:2, bp_pct:40, start_mid:1, abort_word:-1,  chk_first:0, exp_first:32'h0,        exp_words:288};
    vecs[4] = '{mode6:0, pat:0, bp_pct:0,  start_mid:0, abort_word:100, chk_first:0, exp_first:32'h0,        exp_words:0};
    vecs[5] = '{mode6:0, pat:2, bp_pct:0,  start_mid:1, abort_word:-1,  chk_first:0, exp_first:32'h0,        exp_words:192};
    vecs[6] = '{mode6:1, pat:3, bp_pct:20, start_mid:0, abort_word:-1,  chk_first:0, exp_first:32'h0,        exp_words:288};

    ifc.in_valid = 0; ifc.in_coeff = '0; ifc.out_ready = 0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1;

    for (int t = 0; t < 7; t++) run_vec(vecs[t]);

    // Clean 4-bit vector after the earlier error vector: err must clear on start.
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
